// File: rtl/lock_defs.sv
// Shared definitions for the digital lock: state encodings, button roles
// and the press decode helper used by the press encoder.
package lock_defs;

   typedef enum logic [2:0] {
      ST_LOCKED    = 3'd0,
      ST_ENTRY     = 3'd1,
      ST_CHECK     = 3'd2,
      ST_FAIL      = 3'd3,
      ST_LOCKOUT   = 3'd4,
      ST_UNLOCKED  = 3'd5,
      ST_SET_ENTRY = 3'd6
   } lock_state_t;

   localparam logic [1:0] BTN_SET    = 2'd0;
   localparam logic [1:0] BTN_RELOCK = 2'd3;

   typedef struct packed {
      logic       valid;
      logic       multi;
      logic [1:0] index;
   } press_t;

   // Lowest set bit gives the index; multi flags more than one bit set.
   function automatic press_t decode_press(input logic [3:0] presses);
      press_t r;
      r.valid = |presses;
      r.multi = (presses & (presses - 4'd1)) != 4'd0;
      r.index = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (presses[i]) r.index = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/press_encoder.sv
// Combinational decode of the 4 press pulses into {valid, multi, index}.
module press_encoder
   import lock_defs::*;
(
   input  logic [3:0] presses,
   output logic       valid,
   output logic       multi,
   output logic [1:0] index
);

   press_t dec;

   // Single decode point so every consumer sees the same digit rules.
   always_comb begin
      dec = decode_press(presses);
   end

   assign valid = dec.valid;
   assign multi = dec.multi;
   assign index = dec.index;

endmodule

// File: rtl/lock_controller.sv
// Digital lock controller: collects press sequences, checks them against the
// stored code, handles fail/lockout timing and code re-programming.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_LOCKED    | idle and locked, first press starts an entry
// ST_ENTRY     | collecting code digits, idle timeout abandons the entry
// ST_CHECK     | one-cycle compare of the entry against the stored code
// ST_FAIL      | error indicator held, or immediate lockout on MAX_FAILS
// ST_LOCKOUT   | all presses ignored for LOCKOUT_CYCLES
// ST_UNLOCKED  | open; button 3 relocks, button 0 starts re-programming
// ST_SET_ENTRY | collecting a new code, idle timeout returns to unlocked
module lock_controller
   import lock_defs::*;
#(
   parameter int                       CODE_LENGTH    = 4,
   parameter logic [2*CODE_LENGTH-1:0] DEFAULT_CODE   = 8'h1B,
   parameter int                       TIMEOUT_CYCLES = 50_000_000,
   parameter int                       ERROR_CYCLES   = 25_000_000,
   parameter int                       MAX_FAILS      = 3,
   parameter int                       LOCKOUT_CYCLES = 250_000_000
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [3:0]                         buttonPresses,
   output logic                               locked,
   output logic                               unlocked,
   output logic                               error,
   output logic                               lockout,
   output logic [$clog2(CODE_LENGTH+1)-1:0]   digitCount
);

   localparam int CODE_W = 2 * CODE_LENGTH;
   localparam int DC_W   = $clog2(CODE_LENGTH + 1);
   localparam int FC_W   = $clog2(MAX_FAILS + 1);
   localparam int MAX_A  = (TIMEOUT_CYCLES > ERROR_CYCLES) ? TIMEOUT_CYCLES : ERROR_CYCLES;
   localparam int MAX_T  = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
   localparam int TMR_W  = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);

   localparam logic [TMR_W-1:0] TMO_TC  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] ERR_TC  = TMR_W'(ERROR_CYCLES - 1);
   localparam logic [TMR_W-1:0] LKO_TC  = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [DC_W-1:0]  DC_LAST = DC_W'(CODE_LENGTH - 1);
   localparam logic [DC_W-1:0]  DC_FULL = DC_W'(CODE_LENGTH);
   localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(MAX_FAILS);

   lock_state_t       state, state_nxt;
   logic [TMR_W-1:0]  timer;
   logic [DC_W-1:0]   digit_count;
   logic [FC_W-1:0]   fail_count;
   logic [CODE_W-1:0] shift_reg, shift_nxt, stored_code;
   logic              entry_bad, entry_bad_nxt;
   logic              press_valid, press_multi;
   logic [1:0]        press_idx;
   logic              accept_digit, last_digit, code_match;

   press_encoder u_press_encoder (
      .presses (buttonPresses),
      .valid   (press_valid),
      .multi   (press_multi),
      .index   (press_idx)
   );

   assign accept_digit  = press_valid &&
                          (state inside {ST_LOCKED, ST_ENTRY, ST_SET_ENTRY});
   assign last_digit    = (digit_count == DC_LAST);
   assign shift_nxt     = CODE_W'({shift_reg, press_idx});
   assign entry_bad_nxt = (state == ST_LOCKED) ? press_multi : (entry_bad | press_multi);
   assign code_match    = (shift_reg == stored_code) && !entry_bad;

   // Next-state decode; presses outside the entry states only matter in UNLOCKED.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOCKED: begin
            if (accept_digit) state_nxt = last_digit ? ST_CHECK : ST_ENTRY;
         end
         ST_ENTRY: begin
            if (accept_digit) begin
               if (last_digit) state_nxt = ST_CHECK;
            end else if (timer == TMO_TC) begin
               state_nxt = ST_LOCKED;
            end
         end
         ST_CHECK: begin
            state_nxt = code_match ? ST_UNLOCKED : ST_FAIL;
         end
         ST_FAIL: begin
            if (fail_count >= FC_MAX)  state_nxt = ST_LOCKOUT;
            else if (timer == ERR_TC)  state_nxt = ST_LOCKED;
         end
         ST_LOCKOUT: begin
            if (timer == LKO_TC) state_nxt = ST_LOCKED;
         end
         ST_UNLOCKED: begin
            if (press_valid && !press_multi) begin
               if (press_idx == BTN_RELOCK)   state_nxt = ST_LOCKED;
               else if (press_idx == BTN_SET) state_nxt = ST_SET_ENTRY;
            end
         end
         ST_SET_ENTRY: begin
            if (accept_digit) begin
               if (last_digit) state_nxt = ST_LOCKED;
            end else if (timer == TMO_TC) begin
               state_nxt = ST_UNLOCKED;
            end
         end
         default: state_nxt = ST_LOCKED;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_LOCKED;
      else        state <= state_nxt;
   end

   // Shared timer, digit collection, fail tracking and the stored code.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer       <= '0;
         digit_count <= '0;
         fail_count  <= '0;
         shift_reg   <= '0;
         entry_bad   <= 1'b0;
         stored_code <= DEFAULT_CODE;
      end else begin
         if (accept_digit || (state_nxt != state)) timer <= '0;
         else if (timer != '1)                     timer <= timer + 1'b1;

         if (state_nxt inside {ST_CHECK, ST_LOCKED, ST_UNLOCKED}) digit_count <= '0;
         else if (accept_digit && (digit_count != DC_FULL))       digit_count <= digit_count + 1'b1;

         if (accept_digit) shift_reg <= shift_nxt;

         if (state == ST_UNLOCKED) entry_bad <= 1'b0;
         else if (accept_digit)    entry_bad <= entry_bad_nxt;

         if ((state == ST_SET_ENTRY) && accept_digit && last_digit && !entry_bad_nxt)
            stored_code <= shift_nxt;

         if (state == ST_CHECK) begin
            if (code_match)              fail_count <= '0;
            else if (fail_count != FC_MAX) fail_count <= fail_count + 1'b1;
         end else if ((state == ST_LOCKOUT) && (state_nxt == ST_LOCKED)) begin
            fail_count <= '0;
         end
      end
   end

   assign locked     = state inside {ST_LOCKED, ST_ENTRY, ST_CHECK, ST_FAIL, ST_LOCKOUT};
   assign unlocked   = state inside {ST_UNLOCKED, ST_SET_ENTRY};
   assign error      = (state == ST_FAIL);
   assign lockout    = (state == ST_LOCKOUT);
   assign digitCount = digit_count;

endmodule
